fp_div_sequencer: RTL and testbench

//  Multi-cycle controller for the 32-bit IEEE-754 single-precision non-restoring divider.

---
 rtl/fp_div_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sequencer.sv
// Multi-cycle IEEE-754 single-precision divide controller: one non-restoring quotient step per clock.
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even, otherwise the result is truncated.
module fp_div_sequencer #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  exceptions_A,
  input  logic [4:0]  exceptions_B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_DIVIDE, S_NORM, S_DONE} state_t;

  localparam logic [4:0] F_INVALID = 5'b10000;
  localparam logic [4:0] F_DBZ     = 5'b01000;
  localparam logic [4:0] F_OVF     = 5'b00100;
  localparam logic [4:0] F_UNF     = 5'b00010;
  localparam logic [4:0] F_INX     = 5'b00001;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [4:0]         ca_q, ca_d, cb_q, cb_d;
  logic signed [9:0]  e_q, e_d;
  logic [23:0]        d_q, d_d;
  logic [26:0]        r_q, r_d;
  logic [25:0]        qt_q, qt_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;

  // Operand classification and special-case resolution; subnormals count as zero.
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, fin_a, fin_b, sign_ab;
  logic        special;
  logic [31:0] spec_result;
  logic [4:0]  spec_flags;

  always_comb begin
    inf_a   = ca_q[4];
    inf_b   = cb_q[4];
    nan_a   = ca_q[2];
    nan_b   = cb_q[2];
    zero_a  = ca_q[3] | ca_q[1];
    zero_b  = cb_q[3] | cb_q[1];
    fin_a   = ca_q[0] | zero_a;
    fin_b   = cb_q[0] | zero_b;
    sign_ab = a_q[31] ^ b_q[31];
    // NOTE: every branch below starts from these defaults, so no latch can be inferred.
    special     = 1'b1;
    spec_result = QNAN;
    spec_flags  = F_INVALID;
    if (nan_a | nan_b) begin
    end else if (inf_a & inf_b) begin
    end else if (zero_a & zero_b) begin
    end else if (inf_a & fin_b) begin
      spec_result = {sign_ab, 8'hFF, 23'd0};
      spec_flags  = '0;
    end else if (fin_a & inf_b) begin
      spec_result = {sign_ab, 31'd0};
      spec_flags  = '0;
    end else if (zero_b) begin
      spec_result = {sign_ab, 8'hFF, 23'd0};
      spec_flags  = F_DBZ;
    end else if (zero_a) begin
      spec_result = {sign_ab, 31'd0};
      spec_flags  = '0;
    end else begin
      special = 1'b0;
    end
  end

  // Mantissa step, remainder correction, normalization and optional rounding.
  logic [26:0]       r_shl, r_step, r_fix;
  logic              rz, guard, sticky, round_up;
  logic [22:0]       mant;
  logic [23:0]       mant_r;
  logic signed [9:0] e_n, e_r;

  always_comb begin
    r_shl = {r_q[25:0], 1'b0};
    if (cnt_q == 5'd0)  r_step = {4'b0001, a_q[22:0]} - {3'b000, d_q};
    else if (r_q[26])   r_step = r_shl + {3'b000, d_q};
    else                r_step = r_shl - {3'b000, d_q};

    r_fix = r_q[26] ? r_q + {3'b000, d_q} : r_q;
    rz    = |r_fix;
    if (qt_q[25]) begin
      mant   = qt_q[24:2];
      guard  = qt_q[1];
      sticky = qt_q[0] | rz;
      e_n    = e_q;
    end else begin
      mant   = qt_q[23:1];
      guard  = qt_q[0];
      sticky = rz;
      e_n    = e_q - 10'sd1;
    end
`ifdef FP_DIV_ROUND_EN
    round_up = guard & (sticky | mant[0]);
`else
    round_up = 1'b0;
`endif
    // A carry out leaves the mantissa field at zero and bumps the exponent.
    mant_r = {1'b0, mant} + {23'd0, round_up};
    e_r    = mant_r[23] ? e_n + 10'sd1 : e_n;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    e_d      = e_q;
    d_d      = d_q;
    r_d      = r_q;
    qt_d     = qt_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          ca_d    = exceptions_A;
          cb_d    = exceptions_B;
          flags_d = '0;
          busy_d  = 1'b1;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (special) begin
          result_d = spec_result;
          flags_d  = spec_flags;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          e_d     = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd127;
          d_d     = {1'b1, b_q[22:0]};
          r_d     = '0;
          qt_d    = '0;
          cnt_d   = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        r_d   = r_step;
        qt_d  = {qt_q[24:0], ~r_step[26]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (e_r >= 10'sd255) begin
          result_d = {sign_ab, 8'hFF, 23'd0};
          flags_d  = F_OVF | F_INX;
        end else if (e_r <= 10'sd0) begin
          result_d = {sign_ab, 31'd0};
          flags_d  = F_UNF | F_INX;
        end else begin
          result_d = {sign_ab, e_r[7:0], mant_r[22:0]};
          flags_d  = (guard | sticky) ? F_INX : 5'b00000;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ca_q     <= '0;
      cb_q     <= '0;
      e_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      qt_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      e_q      <= e_d;
      d_q      <= d_d;
      r_q      <= r_d;
      qt_q     <= qt_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Randomized self-checking bench for fp_div_sequencer against an arithmetic reference model.
module tb_fp_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic [4:0]  exc_a, exc_b;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  fp_div_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .A            (A),
    .B            (B),
    .exceptions_A (exc_a),
    .exceptions_B (exc_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .flags        (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Class vector as the upstream exception_signals block would present it.
  function automatic logic [4:0] cls(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? 5'b00100 : 5'b10000;
    if (x[30:23] == 8'h00) return (x[22:0] == 23'd0) ? 5'b01000 : 5'b00010;
    return 5'b00001;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [4:0] fl, output int lat);
    bit     nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, s, g, st;
    longint ma, mb, num, q, rem, mant;
    int     e;
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    s      = a[31] ^ b[31];
    lat    = 2;
    fl     = 5'b00000;
    if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
      res = 32'h7FC0_0000;
      fl  = 5'b10000;
    end else if (inf_a) begin
      res = {s, 8'hFF, 23'd0};
    end else if (inf_b) begin
      res = {s, 31'd0};
    end else if (zero_b) begin
      res = {s, 8'hFF, 23'd0};
      fl  = 5'b01000;
    end else if (zero_a) begin
      res = {s, 31'd0};
    end else begin
      lat = 29;
      ma  = longint'({1'b1, a[22:0]});
      mb  = longint'({1'b1, b[22:0]});
      num = ma * (longint'(1) << 25);
      q   = num / mb;
      rem = num % mb;
      e   = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (q >= (longint'(1) << 25)) begin
        mant = (q / 4) % (longint'(1) << 23);
        g    = ((q / 2) % 2) != 0;
        st   = ((q % 2) != 0) || (rem != 0);
      end else begin
        mant = (q / 2) % (longint'(1) << 23);
        g    = (q % 2) != 0;
        st   = rem != 0;
        e    = e - 1;
      end
`ifdef FP_DIV_ROUND_EN
      if (g && (st || (mant % 2) != 0)) begin
        mant = mant + 1;
        if (mant == (longint'(1) << 23)) begin
          mant = 0;
          e    = e + 1;
        end
      end
`endif
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        fl  = 5'b00101;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        fl  = 5'b00011;
      end else begin
        res = {s, 8'(e), 23'(mant)};
        fl  = {4'b0000, g | st};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [31:0] x;
    k = $urandom_range(0, 19);
    x = $urandom;
    case (k)
      0:       x[30:0] = 31'd0;
      1:       x[30:0] = {8'hFF, 23'd0};
      2:       begin x[30:23] = 8'hFF; x[0] = 1'b1; end
      3:       begin x[30:23] = 8'h00; x[0] = 1'b1; end
      4, 5:    x[30:23] = 8'($urandom_range(1, 254));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  // One full operation: latency, busy window, result, flags and hold after the done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit extra);
    logic [31:0] er;
    logic [4:0]  ef;
    int          lat, cyc;
    bit          busy_bad;
    model(a, b, er, ef, lat);
    @(negedge clk);
    A = a; B = b; exc_a = cls(a); exc_b = cls(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_bad = 1'b0;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      A = $urandom; B = $urandom; exc_a = 5'($urandom); exc_b = 5'($urandom);
      start = extra && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'(lat));
    check("busy", {busy_bad, busy}, 2'b00);
    check($sformatf("result %h/%h", a, b), result, er);
    check($sformatf("flags %h/%h", a, b), flags, ef);
    @(negedge clk);
    check("hold", {done, result, flags}, {1'b0, er, ef});
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; exc_a = '0; exc_b = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, result, flags}, '0);
    rst = 1'b0;

    run_op(32'h40C0_0000, 32'h4000_0000, 1'b1);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b0);
    run_op(32'h3F80_0000, 32'h0000_0000, 1'b0);
    run_op(32'hBF80_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(32'h7F80_0001, 32'h3F80_0000, 1'b0);
    run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0);
    run_op(32'h7F00_0000, 32'h0080_0000, 1'b0);
    run_op(32'h0080_0000, 32'h7F00_0000, 1'b0);
    run_op(32'hFF80_0000, 32'h0000_0000, 1'b0);
    run_op(32'h3F80_0000, 32'hFF80_0000, 1'b0);
    run_op(32'h8000_0000, 32'h40A0_0000, 1'b0);
    run_op(32'h0000_0001, 32'h3F80_0000, 1'b0);

    // Reset in the middle of a normal operation aborts it without a done pulse.
    @(negedge clk);
    A = 32'h40C0_0000; B = 32'h4000_0000; exc_a = cls(A); exc_b = cls(B); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_abort", {busy, done, result, flags}, '0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_rst", saw_done, 1'b0);
    run_op(32'h40C0_0000, 32'h4000_0000, 1'b0);

    for (int i = 0; i < 60; i++) run_op(rand_op(), rand_op(), (i % 7) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
